slot_config_ctrl: RTL and testbench

//  Apple II-visible initiator for the slotmaker configuration port. Decodes a
//  4-byte register window on the A2 bus so 6502 software can select a virtual

---
 rtl/slot_config_ctrl.sv | 264 ++++++++++++++++++++++++++
 tb/tb_slot_config_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/slot_config_ctrl.sv
// -----------------------------------------------------------------------------
// slot_config_ctrl
//
// Gives Apple II software a 4-byte register window for the slotmaker
// configuration port. Through this window, 6502 code can:
//   - select a virtual slot,
//   - read back the card ID cached for that slot,
//   - after a two-byte unlock sequence, assign a new card ID to the slot.
//
// Register map (byte offsets from REG_BASE):
//   +0 KEY     (W)   unlock sequence byte
//   +1 SLOT    (R/W) bits[2:0] select the slot; bits[7:3] read as 0
//   +2 CARD    (R)   cached ID of SLOT
//              (W)   request that SLOT be assigned this ID
//   +3 STATUS  (R)   b0 unlocked, b1 busy, b2 reject (sticky), b3 overrun (sticky)
//              (W)   any write clears b2 and b3
//
// Ports:
//   clk_logic       logic clock; all state lives in this domain
//   system_reset_n  asynchronous, active-low reset (released synchronously inside)
//   phi0, m2sel_n   A2 bus phase 0 and M2SEL (active low)
//   addr, rw_n      A2 bus address and direction (1 = 6502 read)
//   data_i          A2 bus write data
//   data_o          registered read data for the bus mux
//   rd_en           high while this block owns a read on the bus
//   cfg_slot        slotmaker configuration slot index
//   cfg_wr          one-clock write strobe to slotmaker
//   cfg_card_i      card ID written to slotmaker
//   cfg_card_o      card ID read back from slotmaker, valid 1 clk after cfg_slot
//
// Bus write handshake:
//   While phi0 is high, the address, direction, data and hit flag are sampled on
//   every clock. On the first clock with phi0 low after phi0 was high, the last
//   sample is committed, provided it was a write that hit this window. The
//   result is exactly one commit per bus cycle.
// -----------------------------------------------------------------------------
module slot_config_ctrl #(
  parameter logic [15:0] REG_BASE = 16'hC0F0,
  parameter logic [7:0]  KEY0     = 8'hA2,
  parameter logic [7:0]  KEY1     = 8'h5A
) (
  input  logic        clk_logic,
  input  logic        system_reset_n,
  input  logic        phi0,
  input  logic        m2sel_n,
  input  logic [15:0] addr,
  input  logic        rw_n,
  input  logic [7:0]  data_i,
  output logic [7:0]  data_o,
  output logic        rd_en,
  output logic [2:0]  cfg_slot,
  output logic        cfg_wr,
  output logic [7:0]  cfg_card_i,
  input  logic [7:0]  cfg_card_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_LATCH, ST_WRITE} state_t;

  localparam logic [1:0] REG_KEY    = 2'd0;
  localparam logic [1:0] REG_SLOT   = 2'd1;
  localparam logic [1:0] REG_CARD   = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  // Reset synchronizer: assertion is asynchronous, release is aligned to the clock.
  logic rst_meta_q, rst_n_q;
  always_ff @(posedge clk_logic or negedge system_reset_n) begin
    if (!system_reset_n) begin
      rst_meta_q <= 1'b0;
      rst_n_q    <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_n_q    <= rst_meta_q;
    end
  end

  // Bus decode and sampling
  logic       hit;
  logic       phi0_q, s_hit_q, s_rw_n_q;
  logic [1:0] s_reg_q;
  logic [7:0] s_data_q;
  logic       commit;

  assign hit    = phi0 & ~m2sel_n & (addr[15:2] == REG_BASE[15:2]);
  assign rd_en  = hit & rw_n;
  assign commit = ~phi0 & phi0_q & s_hit_q & ~s_rw_n_q;

  always_ff @(posedge clk_logic or negedge rst_n_q) begin
    if (!rst_n_q) begin
      phi0_q   <= 1'b0;
      s_hit_q  <= 1'b0;
      s_rw_n_q <= 1'b1;
      s_reg_q  <= 2'd0;
      s_data_q <= 8'd0;
    end else begin
      phi0_q <= phi0;
      if (phi0) begin
        s_hit_q  <= hit;
        s_rw_n_q <= rw_n;
        s_reg_q  <= addr[1:0];
        s_data_q <= data_i;
      end
    end
  end

  // Architectural state
  state_t     state_q, state_d;
  logic [2:0] slot_q, slot_d;
  logic       unlocked_q, unlocked_d;
  logic       key0_seen_q, key0_seen_d;
  logic       reject_q, reject_d;
  logic       overrun_q, overrun_d;
  logic       pend_valid_q, pend_valid_d;
  logic       pend_wr_q, pend_wr_d;
  logic [7:0] pend_data_q, pend_data_d;
  logic [7:0] cache_q, cache_d;
  logic [2:0] cfg_slot_q, cfg_slot_d;
  logic       cfg_wr_q, cfg_wr_d;
  logic [7:0] cfg_card_i_q, cfg_card_i_d;
  logic [7:0] data_o_q, data_o_d;

  logic       busy, card_ok, req, req_wr;
  logic       launch, launch_wr;
  logic [7:0] launch_data;
  logic [7:0] status;

  assign busy    = (state_q != ST_IDLE);
  assign card_ok = unlocked_q & (slot_q != 3'd0);
  // Commits that need a slotmaker transaction: any SLOT write, or an accepted CARD write.
  assign req     = commit & ((s_reg_q == REG_SLOT) | ((s_reg_q == REG_CARD) & card_ok));
  assign req_wr  = (s_reg_q == REG_CARD);
  assign status  = {4'b0000, overrun_q, reject_q, busy, unlocked_q};

  always_comb begin
    slot_d      = slot_q;
    unlocked_d  = unlocked_q;
    key0_seen_d = key0_seen_q;
    reject_d    = reject_q;
    overrun_d   = overrun_q;
    if (commit) begin
      case (s_reg_q)
        REG_KEY: begin
          if (s_data_q == KEY0) begin
            key0_seen_d = 1'b1;
          end else if ((s_data_q == KEY1) && key0_seen_q) begin
            unlocked_d  = 1'b1;
            key0_seen_d = 1'b0;
          end else begin
            unlocked_d  = 1'b0;
            key0_seen_d = 1'b0;
          end
        end
        REG_SLOT:   slot_d = s_data_q[2:0];
        REG_CARD:   if (!card_ok) reject_d = 1'b1;
        default: begin
          reject_d  = 1'b0;
          overrun_d = 1'b0;
        end
      endcase
    end
    // The single pending entry stays occupied through the clock it launches in.
    if (req && pend_valid_q) overrun_d = 1'b1;
  end

  always_comb begin
    state_d      = state_q;
    pend_valid_d = pend_valid_q;
    pend_wr_d    = pend_wr_q;
    pend_data_d  = pend_data_q;
    cache_d      = cache_q;
    cfg_slot_d   = cfg_slot_q;
    cfg_wr_d     = 1'b0;
    cfg_card_i_d = cfg_card_i_q;
    launch       = 1'b0;
    launch_wr    = 1'b0;
    launch_data  = 8'd0;
    case (state_q)
      ST_IDLE: begin
        if (pend_valid_q) begin
          launch       = 1'b1;
          launch_wr    = pend_wr_q;
          launch_data  = pend_data_q;
          pend_valid_d = 1'b0;
        end else if (req) begin
          launch      = 1'b1;
          launch_wr   = req_wr;
          launch_data = s_data_q;
        end
      end
      ST_WRITE: state_d = ST_FETCH;
      ST_FETCH: state_d = ST_LATCH;
      default: begin
        cache_d = cfg_card_o;
        state_d = ST_IDLE;
      end
    endcase
    // A request that could not launch is parked when the buffer is free.
    if (req && busy && !pend_valid_q) begin
      pend_valid_d = 1'b1;
      pend_wr_d    = req_wr;
      pend_data_d  = s_data_q;
    end
    if (launch) begin
      // slot_d so a SLOT commit in this same clock selects the new slot.
      cfg_slot_d = slot_d;
      if (launch_wr) begin
        state_d      = ST_WRITE;
        cfg_wr_d     = 1'b1;
        cfg_card_i_d = launch_data;
      end else begin
        state_d = ST_FETCH;
      end
    end
  end

  always_comb begin
    case (addr[1:0])
      REG_SLOT:   data_o_d = {5'b00000, slot_q};
      REG_CARD:   data_o_d = cache_q;
      REG_STATUS: data_o_d = status;
      default:    data_o_d = 8'd0;
    endcase
  end

  // Reset lands in FETCH so the cache is filled for slot 0 right after release.
  always_ff @(posedge clk_logic or negedge rst_n_q) begin
    if (!rst_n_q) begin
      state_q      <= ST_FETCH;
      slot_q       <= 3'd0;
      unlocked_q   <= 1'b0;
      key0_seen_q  <= 1'b0;
      reject_q     <= 1'b0;
      overrun_q    <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_wr_q    <= 1'b0;
      pend_data_q  <= 8'd0;
      cache_q      <= 8'd0;
      cfg_slot_q   <= 3'd0;
      cfg_wr_q     <= 1'b0;
      cfg_card_i_q <= 8'd0;
      data_o_q     <= 8'd0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      unlocked_q   <= unlocked_d;
      key0_seen_q  <= key0_seen_d;
      reject_q     <= reject_d;
      overrun_q    <= overrun_d;
      pend_valid_q <= pend_valid_d;
      pend_wr_q    <= pend_wr_d;
      pend_data_q  <= pend_data_d;
      cache_q      <= cache_d;
      cfg_slot_q   <= cfg_slot_d;
      cfg_wr_q     <= cfg_wr_d;
      cfg_card_i_q <= cfg_card_i_d;
      data_o_q     <= data_o_d;
    end
  end

  assign data_o     = data_o_q;
  assign cfg_slot   = cfg_slot_q;
  assign cfg_wr     = cfg_wr_q;
  assign cfg_card_i = cfg_card_i_q;

endmodule

// File: tb/tb_slot_config_ctrl.sv
module tb_slot_config_ctrl;

  localparam logic [15:0] A_KEY  = 16'hC0F0;
  localparam logic [15:0] A_SLOT = 16'hC0F1;
  localparam logic [15:0] A_CARD = 16'hC0F2;
  localparam logic [15:0] A_STAT = 16'hC0F3;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        system_reset_n;
  logic        phi0, m2sel_n, rw_n;
  logic [15:0] addr;
  logic [7:0]  data_i;
  logic [7:0]  data_o;
  logic        rd_en;
  logic [2:0]  cfg_slot;
  logic        cfg_wr;
  logic [7:0]  cfg_card_i;
  logic [7:0]  cfg_card_o;

  always #5 clk = ~clk;

  slot_config_ctrl dut (
    .clk_logic      (clk),
    .system_reset_n (system_reset_n),
    .phi0           (phi0),
    .m2sel_n        (m2sel_n),
    .addr           (addr),
    .rw_n           (rw_n),
    .data_i         (data_i),
    .data_o         (data_o),
    .rd_en          (rd_en),
    .cfg_slot       (cfg_slot),
    .cfg_wr         (cfg_wr),
    .cfg_card_i     (cfg_card_i),
    .cfg_card_o     (cfg_card_o)
  );

  // ---------------- slotmaker model ----------------
  // Registered read-back; power-on contents are loaded on the first clock.
  // Slot 0 = A0, slot 3 = 05, every other slot i = 8'h10 + i.
  logic [7:0] cards [8];
  logic       sm_init = 1'b0;
  always @(posedge clk) begin
    if (!sm_init) begin
      for (int i = 0; i < 8; i++) cards[i] <= 8'h10 + 8'(i);
      cards[0] <= 8'hA0;
      cards[3] <= 8'h05;
      sm_init  <= 1'b1;
    end else begin
      cfg_card_o <= cards[cfg_slot];
      if (cfg_wr) cards[cfg_slot] <= cfg_card_i;
    end
  end

  // ---------------- scoreboard ----------------
  logic [7:0]  exp_q [$];   // expected read data, in bus order
  logic [10:0] wr_q  [$];   // expected {slot, card} per cfg_wr pulse
  logic [15:0] cur_addr;
  int          n_vec = 0;
  int          n_err = 0;
  int          rd_cnt = 0;

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Monitor: read data is taken on the 2nd phi0-high clock of a read cycle;
  // every cfg_wr pulse must match the next queued slotmaker write.
  always @(negedge clk) begin
    logic [7:0]  e;
    logic [10:0] w;
    if (rd_en) rd_cnt++;
    else rd_cnt = 0;
    if (rd_en && rd_cnt == 2) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL rd_unexpected addr=%h got=%h", cur_addr, data_o);
      end else begin
        e = exp_q.pop_front();
        if (data_o !== e) begin
          n_err++;
          $display("FAIL rd_data addr=%h got=%h exp=%h", cur_addr, data_o, e);
        end
      end
    end
    if (cfg_wr) begin
      n_vec++;
      if (wr_q.size() == 0) begin
        n_err++;
        $display("FAIL cfg_wr_unexpected slot=%0d card=%h", cfg_slot, cfg_card_i);
      end else begin
        w = wr_q.pop_front();
        if ({cfg_slot, cfg_card_i} !== w) begin
          n_err++;
          $display("FAIL cfg_wr_data got=%0d/%h exp=%0d/%h", cfg_slot, cfg_card_i, w[10:8], w[7:0]);
        end
      end
    end
  end

  // ---------------- drivers ----------------
  // Called #1 after a rising edge; return #1 after a rising edge.
  task automatic bus_write(input logic [15:0] a, input logic [7:0] d, input int hi, input int lo);
    addr = a; data_i = d; rw_n = 1'b0; m2sel_n = 1'b0; phi0 = 1'b1;
    repeat (hi) begin @(posedge clk); #1; end
    phi0 = 1'b0; m2sel_n = 1'b1; rw_n = 1'b1;
    repeat (lo) begin @(posedge clk); #1; end
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    bus_write(a, d, 2, 4);
  endtask

  task automatic rd(input logic [15:0] a, input logic [7:0] exp);
    exp_q.push_back(exp);
    cur_addr = a;
    addr = a; rw_n = 1'b1; m2sel_n = 1'b0; phi0 = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    phi0 = 1'b0; m2sel_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    phi0 = 1'b0; m2sel_n = 1'b1; rw_n = 1'b1; addr = 16'h0000; data_i = 8'h00;
    system_reset_n = 1'b1;
    #3 system_reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data_o", data_o, 8'h00);
    check("rst_cfg_wr", {7'd0, cfg_wr}, 8'h00);
    check("rst_cfg_slot", {5'd0, cfg_slot}, 8'h00);
    check("rst_cfg_card_i", cfg_card_i, 8'h00);
    check("rst_rd_en", {7'd0, rd_en}, 8'h00);
    system_reset_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;

    // Post-reset fill of slot 0, then select slot 3
    rd(A_CARD, 8'hA0);
    rd(A_STAT, 8'h00);
    wr(A_SLOT, 8'hF3);           // upper bits ignored
    rd(A_SLOT, 8'h03);
    rd(A_CARD, 8'h05);
    rd(A_STAT, 8'h00);

    // Unlock and assign slot 3 = 07
    wr(A_KEY, 8'hA2);
    wr(A_KEY, 8'h5A);
    rd(A_STAT, 8'h01);
    wr(A_SLOT, 8'h03);
    wr_q.push_back({3'd3, 8'h07});
    wr(A_CARD, 8'h07);
    rd(A_CARD, 8'h07);
    rd(A_STAT, 8'h01);

    // Reject on SLOT==0 while unlocked, then clear
    wr(A_SLOT, 8'h00);
    rd(A_CARD, 8'hA0);
    wr(A_CARD, 8'h09);
    rd(A_STAT, 8'h05);
    wr(A_STAT, 8'hFF);
    rd(A_STAT, 8'h01);

    // Reject while locked
    wr(A_KEY, 8'h00);
    wr(A_SLOT, 8'h03);
    wr(A_CARD, 8'h09);
    rd(A_STAT, 8'h04);
    rd(A_CARD, 8'h07);
    wr(A_STAT, 8'h00);
    rd(A_STAT, 8'h00);

    // Broken key sequence, then key split by a non-KEY commit
    wr(A_KEY, 8'hA2);
    wr(A_KEY, 8'h00);
    wr(A_KEY, 8'h5A);
    rd(A_STAT, 8'h00);
    wr(A_KEY, 8'hA2);
    wr(A_SLOT, 8'h02);
    wr(A_KEY, 8'h5A);
    rd(A_STAT, 8'h01);
    rd(A_SLOT, 8'h02);
    rd(A_CARD, 8'h12);

    // Three back-to-back commits: CARD runs, SLOT=4 is held, CARD 0C is dropped
    wr(A_SLOT, 8'h03);
    wr_q.push_back({3'd3, 8'h0B});
    bus_write(A_CARD, 8'h0B, 1, 1);
    bus_write(A_SLOT, 8'h04, 1, 1);
    bus_write(A_CARD, 8'h0C, 1, 1);
    repeat (8) begin @(posedge clk); #1; end
    rd(A_SLOT, 8'h04);
    rd(A_CARD, 8'h14);
    rd(A_STAT, 8'h09);
    wr(A_STAT, 8'h00);
    rd(A_STAT, 8'h01);
    wr(A_SLOT, 8'h03);
    rd(A_CARD, 8'h0B);

    // Reset while the WRITE strobe is up
    bus_write(A_CARD, 8'h0D, 2, 0);
    @(posedge clk);
    #2;
    check("mid_cfg_wr_high", {7'd0, cfg_wr}, 8'h01);
    check("mid_cfg_card_i", cfg_card_i, 8'h0D);
    system_reset_n = 1'b0;
    #1;
    check("mid_rst_cfg_wr", {7'd0, cfg_wr}, 8'h00);
    check("mid_rst_cfg_slot", {5'd0, cfg_slot}, 8'h00);
    repeat (3) @(posedge clk);
    #1 system_reset_n = 1'b1;
    repeat (8) begin @(posedge clk); #1; end
    rd(A_CARD, 8'hA0);
    rd(A_SLOT, 8'h00);
    rd(A_STAT, 8'h00);
    wr(A_SLOT, 8'h03);
    rd(A_CARD, 8'h0B);

    repeat (4) begin @(posedge clk); #1; end
    check("exp_q_drained", 8'(exp_q.size()), 8'h00);
    check("wr_q_drained", 8'(wr_q.size()), 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
